// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage for a multi-cycle control unit. Holds PC and IR, fetches one instruction per
// IRwrite strobe over a req/ack memory handshake, and executes the PCWrite / PCWriteCond /
// PCsrc strobes. stall holds the control unit while a fetch is outstanding.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch after TIMEOUT un-acked WAIT
// cycles and raise the sticky fetch_err flag. Without it a fetch waits for ack indefinitely.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   ir_write        start a fetch (ignored while one is outstanding)
//   pc_write        unconditional PC write
//   pc_write_cond   PC write qualified by zero
//   zero            ALU zero flag
//   pc_src          0: alu_res, 1: branch_tgt, 2: ir[11:0], 3: hold
//   alu_res         ALU result (PC+1 during fetch)
//   branch_tgt      branch target
//   mem_req         instruction memory request
//   mem_addr        request address (= pc)
//   mem_ack         memory ack, mem_rdata valid while high
//   mem_rdata       instruction word
//   pc, ir          program counter, instruction register
//   opc, func       ir[15:12], ir[8:0]
//   stall           combinational fetch-in-progress hold
//   fetch_err       sticky fetch timeout flag (tied low without FETCH_TIMEOUT_EN)
module instr_fetch_unit #(
    parameter int unsigned AW      = 12,
    parameter int unsigned IW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ir_write,
    input  logic          pc_write,
    input  logic          pc_write_cond,
    input  logic          zero,
    input  logic [1:0]    pc_src,
    input  logic [AW-1:0] alu_res,
    input  logic [AW-1:0] branch_tgt,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    output logic [AW-1:0] pc,
    output logic [IW-1:0] ir,
    output logic [3:0]    opc,
    output logic [8:0]    func,
    output logic          stall,
    output logic          fetch_err
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] ir_q;
    logic          load_ir;
    logic          pc_en;
    logic          timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    // cnt_q holds the number of un-acked WAIT cycles already completed, so the abort
    // lands on the TIMEOUT-th WAIT cycle.
    assign timeout_hit = (state_q == StWait) && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && ir_write) begin
            cnt_d = '0;
        end else if (state_q == StWait && !mem_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
    assign fetch_err      = 1'b0;
`endif

    // FSM next state and stall; a timed-out fetch releases stall so the PC update applies.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        load_ir = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ir_write) begin
                    state_d = StWait;
                    stall   = 1'b1;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d = StIdle;
                    load_ir = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc_en = (pc_write || (pc_write_cond && zero)) && !stall;

    // Jump target reads the current IR; an IR load on the same edge does not affect it.
    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            unique case (pc_src)
                2'd0:    pc_d = alu_res;
                2'd1:    pc_d = branch_tgt;
                2'd2:    pc_d = AW'(ir_q[11:0]);
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (load_ir) begin
                ir_q <= mem_rdata;
            end
        end
    end

    assign mem_req  = (state_q == StWait);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign opc      = ir_q[15:12];
    assign func     = ir_q[8:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_write, pc_write, pc_write_cond, zero;
    logic [1:0]  pc_src;
    logic [11:0] alu_res, branch_tgt;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [11:0] pc;
    logic [15:0] ir;
    logic [3:0]  opc;
    logic [8:0]  func;
    logic        stall;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .AW(12),
        .IW(16),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .pc_write_cond(pc_write_cond),
        .zero(zero),
        .pc_src(pc_src),
        .alu_res(alu_res),
        .branch_tgt(branch_tgt),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .pc(pc),
        .ir(ir),
        .opc(opc),
        .func(func),
        .stall(stall),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ir_write = 0; pc_write = 0; pc_write_cond = 0; zero = 0; pc_src = 0;
        alu_res = 0; branch_tgt = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    // Stimulus helpers (entered and left at a falling edge).
    task automatic set_pc(input logic [11:0] v);
        pc_write = 1; pc_src = 2'd1; branch_tgt = v;
        @(negedge clk);
        pc_write = 0; pc_src = 2'd0;
    endtask

    task automatic do_fetch(input logic [15:0] data);
        ir_write = 1;
        @(negedge clk);
        mem_ack = 1; mem_rdata = data;
        @(negedge clk);
        ir_write = 0; mem_ack = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got %h want 000", pc); end
        total++; if (ir !== 16'h0000) begin bad++; $display("FAIL reset_ir got %h want 0000", ir); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", mem_req); end
        total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", fetch_err); end
        rst = 1;
        @(negedge clk);
        do_fetch(16'h5A5A);
        set_pc(12'h123);
        ir_write = 1;
        @(negedge clk);
        ir_write = 0;
        #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_prereq got %b want 1", mem_req); end
        #2 rst = 0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_midreq got %b want 0", mem_req); end
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_midpc got %h want 000", pc); end
        total++; if (ir !== 16'h0000) begin bad++; $display("FAIL reset_midir got %h want 0000", ir); end
        @(negedge clk);
        rst = 1; mem_ack = 1; mem_rdata = 16'hBEEF;
        @(negedge clk);
        mem_ack = 0;
        #1;
        total++; if (ir !== 16'h0000) begin bad++; $display("FAIL reset_lateack got %h want 0000", ir); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_lateack_req got %b want 0", mem_req); end
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        int scount = 0;
        set_pc(12'h010);
        ir_write = 1; pc_write = 1; pc_src = 2'd0; alu_res = 12'h011;
        #1;
        if (stall) scount++;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL zw_req0 got %b want 0", mem_req); end
        @(negedge clk);
        mem_ack = 1; mem_rdata = 16'hC123;
        #1;
        if (stall) scount++;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL zw_req1 got %b want 1", mem_req); end
        total++; if (mem_addr !== 12'h010) begin bad++; $display("FAIL zw_addr got %h want 010", mem_addr); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (ir !== 16'hC123) begin bad++; $display("FAIL zw_ir got %h want c123", ir); end
        total++; if (opc !== 4'hC) begin bad++; $display("FAIL zw_opc got %h want c", opc); end
        total++; if (func !== 9'h123) begin bad++; $display("FAIL zw_func got %h want 123", func); end
        total++; if (pc !== 12'h011) begin bad++; $display("FAIL zw_pc got %h want 011", pc); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL zw_req_end got %b want 0", mem_req); end
        total++; if (scount != 1) begin bad++; $display("FAIL zw_stall_cycles got %0d want 1", scount); end
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        int scount = 0;
        set_pc(12'h010);
        ir_write = 1; pc_write = 1; pc_src = 2'd0; alu_res = 12'h011;
        #1;
        if (stall) scount++;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            mem_ack = (w == 2); mem_rdata = 16'h1357;
            #1;
            if (stall) scount++;
            total++; if (mem_addr !== 12'h010 || pc !== 12'h010 || mem_req !== 1'b1) begin
                bad++; $display("FAIL ws_hold w=%0d got addr=%h pc=%h req=%b want 010/010/1",
                                w, mem_addr, pc, mem_req);
            end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        total++; if (scount != 3) begin bad++; $display("FAIL ws_stall_cycles got %0d want 3", scount); end
        total++; if (pc !== 12'h011) begin bad++; $display("FAIL ws_pc got %h want 011", pc); end
        total++; if (ir !== 16'h1357) begin bad++; $display("FAIL ws_ir got %h want 1357", ir); end
        @(negedge clk);
    endtask

    task automatic test_jump();
        do_fetch(16'h2ABC);
        pc_write = 1; pc_src = 2'd2;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL jmp_stall got %b want 0", stall); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (pc !== 12'hABC) begin bad++; $display("FAIL jmp_pc got %h want abc", pc); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL jmp_req got %b want 0", mem_req); end
        @(negedge clk);
    endtask

    task automatic test_branch();
        pc_write_cond = 1; pc_src = 2'd1; branch_tgt = 12'h055; zero = 0;
        @(negedge clk);
        #1;
        total++; if (pc !== 12'hABC) begin bad++; $display("FAIL br_nottaken got %h want abc", pc); end
        zero = 1;
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (pc !== 12'h055) begin bad++; $display("FAIL br_taken got %h want 055", pc); end
        @(negedge clk);
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        logic [15:0] ir_before;
        ir_before = 16'h2ABC;
        ir_write = 1;
        @(negedge clk);
        ir_write = 0; pc_write = 1; pc_src = 2'd1; branch_tgt = 12'h077;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!mem_req) break;
            cnt++;
            total++; if (stall !== (cnt < int'(TIMEOUT))) begin
                bad++; $display("FAIL to_stall cycle=%0d got %b want %b", cnt, stall, cnt < int'(TIMEOUT));
            end
            total++; if (cnt < int'(TIMEOUT) && pc !== 12'h055) begin
                bad++; $display("FAIL to_pc_hold cycle=%0d got %h want 055", cnt, pc);
            end
            @(negedge clk);
        end
        clear_inputs();
        total++; if (cnt != int'(TIMEOUT)) begin bad++; $display("FAIL to_req_cycles got %0d want %0d", cnt, TIMEOUT); end
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL to_err got %b want 1", fetch_err); end
        total++; if (ir !== ir_before) begin bad++; $display("FAIL to_ir got %h want %h", ir, ir_before); end
        total++; if (pc !== 12'h077) begin bad++; $display("FAIL to_pc got %h want 077", pc); end
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        ir_write = 1;
        @(negedge clk);
        ir_write = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            total++; if (mem_req !== 1'b1 || stall !== 1'b1 || fetch_err !== 1'b0) begin
                bad++; $display("FAIL nto_wait cycle=%0d got req=%b stall=%b err=%b want 1/1/0",
                                i, mem_req, stall, fetch_err);
            end
            @(negedge clk);
        end
        mem_ack = 1; mem_rdata = 16'h2ABC;
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL nto_end got %b want 0", mem_req); end
        @(negedge clk);
    endtask
`endif

    // Random traffic against a transaction-level model: a fetch is either pending or not,
    // and the memory word lands in IR when an ack arrives while pending.
    task automatic test_random();
        logic [11:0] m_pc, n_pc;
        logic [15:0] m_ir;
        bit          m_pending, m_err, abort, stall_e, pc_en;
        int          m_waited;
        rst = 0;
        clear_inputs();
        @(negedge clk);
        rst = 1;
        m_pc = 0; m_ir = 0; m_pending = 0; m_err = 0; m_waited = 0;
        for (int c = 0; c < 400; c++) begin
            ir_write      = ($urandom_range(0, 3) == 0);
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            zero          = ($urandom_range(0, 1) == 0);
            pc_src        = 2'($urandom_range(0, 3));
            alu_res       = 12'($urandom);
            branch_tgt    = 12'($urandom);
            mem_ack       = ($urandom_range(0, 2) == 0);
            mem_rdata     = 16'($urandom);
            abort = 0;
`ifdef FETCH_TIMEOUT_EN
            if (m_pending && !mem_ack && (m_waited + 1 == int'(TIMEOUT))) abort = 1;
`endif
            stall_e = m_pending ? (!mem_ack && !abort) : ir_write;
            #1;
            total++; if (stall !== stall_e) begin bad++; $display("FAIL rnd_stall c=%0d got %b want %b", c, stall, stall_e); end
            total++; if (mem_req !== m_pending) begin bad++; $display("FAIL rnd_req c=%0d got %b want %b", c, mem_req, m_pending); end
            total++; if (pc !== m_pc || mem_addr !== m_pc) begin
                bad++; $display("FAIL rnd_pc c=%0d got pc=%h addr=%h want %h", c, pc, mem_addr, m_pc);
            end
            total++; if (ir !== m_ir || opc !== 4'(m_ir / 4096) || func !== 9'(m_ir % 512)) begin
                bad++; $display("FAIL rnd_ir c=%0d got ir=%h opc=%h func=%h want ir=%h", c, ir, opc, func, m_ir);
            end
            total++; if (fetch_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got %b want %b", c, fetch_err, m_err); end
            pc_en = (pc_write || (pc_write_cond && zero)) && !stall_e;
            n_pc = m_pc;
            if (pc_en) begin
                if (pc_src == 0) n_pc = alu_res;
                else if (pc_src == 1) n_pc = branch_tgt;
                else if (pc_src == 2) n_pc = 12'(m_ir % 4096);
            end
            @(posedge clk);
            m_pc = n_pc;
            if (m_pending && mem_ack) m_ir = mem_rdata;
            if (abort) m_err = 1;
            if (m_pending) begin
                m_waited  = m_waited + 1;
                m_pending = !(mem_ack || abort);
            end else begin
                m_waited  = 0;
                m_pending = ir_write;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jump();
        test_branch();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
